// File: rtl/snake_body.sv
// Snake body engine: circular segment buffer, step/grow/turn control, wall and self collision.
// Define SNAKE_WRAP_EN to make edge moves wrap around the grid instead of killing the snake.
module snake_body #(
    parameter int unsigned GRID_W   = 64,
    parameter int unsigned GRID_H   = 48,
    parameter int unsigned XW       = 7,
    parameter int unsigned YW       = 6,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned START_X  = 3,
    parameter int unsigned START_Y  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic                         restart,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir_req,
    input  logic                         grow,
    input  logic [XW-1:0]                query_x,
    input  logic [YW-1:0]                query_y,
    output logic                         query_hit,
    output logic                         query_head,
    output logic [XW-1:0]                head_x,
    output logic [YW-1:0]                head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         busy,
    output logic                         dead
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StRun, StCheck, StDead} state_e;

    state_e          state_q;
    logic [XW-1:0]   seg_x_q [MAX_LEN];
    logic [YW-1:0]   seg_y_q [MAX_LEN];
    logic [IW-1:0]   hp_q;
    logic [LW-1:0]   len_q;
    logic [1:0]      dir_q;
    logic [1:0]      pend_dir_q;
    logic            grow_pend_q;
    logic [XW-1:0]   cand_x_q;
    logic [YW-1:0]   cand_y_q;
    logic            cand_wall_q;
    logic            query_hit_q;
    logic            query_head_q;

    // Segment view rotated so index 0 is always the head.
    logic [XW-1:0]   rot_x [MAX_LEN];
    logic [YW-1:0]   rot_y [MAX_LEN];
    logic            live  [MAX_LEN];
    logic            tail  [MAX_LEN];

    logic [XW-1:0]   nxt_x;
    logic [YW-1:0]   nxt_y;
    logic            nxt_wall;
    logic            self_hit;
    logic [IW-1:0]   hp_dec;
    logic            q_in_grid;
    logic            q_hit;
    logic            q_head;
    logic            dir_ok;

    function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= MAX_LEN) s = s - MAX_LEN;
        return IW'(s);
    endfunction

    function automatic logic [XW-1:0] init_x(input int unsigned i);
        return (i < INIT_LEN) ? XW'(START_X - i) : '0;
    endfunction

    function automatic logic [YW-1:0] init_y(input int unsigned i);
        return (i < INIT_LEN) ? YW'(START_Y) : '0;
    endfunction

    function automatic logic [1:0] reverse(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            rot_x[i] = seg_x_q[slot(hp_q, i)];
            rot_y[i] = seg_y_q[slot(hp_q, i)];
            live[i]  = LW'(i) < len_q;
            tail[i]  = LW'(i) == (len_q - LW'(1));
        end
    end

    assign head_x = rot_x[0];
    assign head_y = rot_y[0];
    assign hp_dec = (hp_q == '0) ? IW'(MAX_LEN - 1) : hp_q - 1'b1;
    assign dir_ok = dir_valid && (dir_req != reverse(dir_q));

    always_comb begin
        nxt_x    = head_x;
        nxt_y    = head_y;
        nxt_wall = 1'b0;
        case (pend_dir_q)
            2'd0: begin
                if (head_x == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    nxt_x = '0;
`else
                    nxt_wall = 1'b1;
`endif
                end else begin
                    nxt_x = head_x + 1'b1;
                end
            end
            2'd1: begin
                if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
                    nxt_x = XW'(GRID_W - 1);
`else
                    nxt_wall = 1'b1;
`endif
                end else begin
                    nxt_x = head_x - 1'b1;
                end
            end
            2'd2: begin
                if (head_y == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    nxt_y = '0;
`else
                    nxt_wall = 1'b1;
`endif
                end else begin
                    nxt_y = head_y + 1'b1;
                end
            end
            default: begin
                if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
                    nxt_y = YW'(GRID_H - 1);
`else
                    nxt_wall = 1'b1;
`endif
                end else begin
                    nxt_y = head_y - 1'b1;
                end
            end
        endcase
    end

    // The tail moves away in the same step unless the snake is growing.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (live[i] && !(tail[i] && !grow_pend_q) &&
                rot_x[i] == cand_x_q && rot_y[i] == cand_y_q) begin
                self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        q_in_grid = (32'(query_x) < GRID_W) && (32'(query_y) < GRID_H);
        q_hit     = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (live[i] && rot_x[i] == query_x && rot_y[i] == query_y) q_hit = 1'b1;
        end
        q_hit  = q_hit && q_in_grid;
        q_head = q_in_grid && head_x == query_x && head_y == query_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query_hit_q  <= 1'b0;
            query_head_q <= 1'b0;
        end else begin
            query_hit_q  <= q_hit;
            query_head_q <= q_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            hp_q        <= '0;
            len_q       <= LW'(INIT_LEN);
            dir_q       <= 2'd0;
            pend_dir_q  <= 2'd0;
            grow_pend_q <= 1'b0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            cand_wall_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else if (restart) begin
            state_q     <= StRun;
            hp_q        <= '0;
            len_q       <= LW'(INIT_LEN);
            dir_q       <= 2'd0;
            pend_dir_q  <= 2'd0;
            grow_pend_q <= 1'b0;
            cand_wall_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            case (state_q)
                StRun: begin
                    if (dir_ok) pend_dir_q <= dir_req;
                    if (grow) grow_pend_q <= 1'b1;
                    if (step) begin
                        cand_x_q    <= nxt_x;
                        cand_y_q    <= nxt_y;
                        cand_wall_q <= nxt_wall;
                        dir_q       <= pend_dir_q;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (dir_ok) pend_dir_q <= dir_req;
                    if (cand_wall_q || self_hit) begin
                        grow_pend_q <= 1'b0;
                        state_q     <= StDead;
                    end else begin
                        hp_q            <= hp_dec;
                        seg_x_q[hp_dec] <= cand_x_q;
                        seg_y_q[hp_dec] <= cand_y_q;
                        if (grow_pend_q && len_q < LW'(MAX_LEN)) len_q <= len_q + 1'b1;
                        // A grow arriving now belongs to the next step.
                        grow_pend_q     <= grow;
                        state_q         <= StRun;
                    end
                end
                StDead: ;
                default: state_q <= StRun;
            endcase
        end
    end

    assign query_hit  = query_hit_q;
    assign query_head = query_head_q;
    assign length     = len_q;
    assign busy       = (state_q == StCheck);
    assign dead       = (state_q == StDead);

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: query table at reset, then movement, growth and collision sequences.
// Expectations follow SNAKE_WRAP_EN when it is defined for the build.
module tb_snake_body;

    localparam int XW = 7;
    localparam int YW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          step = 1'b0;
    logic          restart = 1'b0;
    logic          dir_valid = 1'b0;
    logic [1:0]    dir_req = 2'd0;
    logic          grow = 1'b0;
    logic [XW-1:0] query_x = '0;
    logic [YW-1:0] query_y = '0;
    logic          query_hit;
    logic          query_head;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [4:0]    length;
    logic          busy;
    logic          dead;

    snake_body dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .restart    (restart),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .grow       (grow),
        .query_x    (query_x),
        .query_y    (query_y),
        .query_hit  (query_hit),
        .query_head (query_head),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .busy       (busy),
        .dead       (dead)
    );

    always #20 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int qx;
        int qy;
        int hit;
        int head;
    } qvec_t;

    qvec_t rv[8];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_query(input string name, input int qx, input int qy,
                               input int exp_hit, input int exp_head);
        @(negedge clk);
        query_x = XW'(qx);
        query_y = YW'(qy);
        @(negedge clk);
        check({name, ".hit"}, int'(query_hit), exp_hit);
        check({name, ".head"}, int'(query_head), exp_head);
    endtask

    task automatic check_head(input string name, input int x, input int y);
        check({name, ".x"}, int'(head_x), x);
        check({name, ".y"}, int'(head_y), y);
    endtask

    task automatic do_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        dir_valid = 1'b1;
        dir_req   = d;
        @(negedge clk) dir_valid = 1'b0;
    endtask

    task automatic pulse_grow();
        @(negedge clk) grow = 1'b1;
        @(negedge clk) grow = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        rv[0] = '{3, 0, 1, 1};
        rv[1] = '{2, 0, 1, 0};
        rv[2] = '{1, 0, 1, 0};
        rv[3] = '{0, 0, 1, 0};
        rv[4] = '{4, 0, 0, 0};
        rv[5] = '{3, 1, 0, 0};
        rv[6] = '{100, 0, 0, 0};
        rv[7] = '{0, 47, 0, 0};

        #2 rst = 1'b1;
        #10;
        check("rst.query_hit", int'(query_hit), 0);
        check("rst.query_head", int'(query_head), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.dead", int'(dead), 0);
        check("rst.length", int'(length), 4);
        check_head("rst.head", 3, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check_query($sformatf("reset_q%0d", i), rv[i].qx, rv[i].qy, rv[i].hit, rv[i].head);
        end

        // Reverse request while moving right is dropped.
        set_dir(2'd1);
        do_step();
        check_head("reverse", 4, 0);

        // Back-to-back step pulses: only alternate ones are taken.
        @(negedge clk) step = 1'b1;
        @(negedge clk) check("bb.busy0", int'(busy), 1);
        @(negedge clk) begin
            check("bb.x1", int'(head_x), 5);
            check("bb.busy1", int'(busy), 0);
        end
        @(negedge clk) check("bb.busy2", int'(busy), 1);
        @(negedge clk) step = 1'b0;
        check("bb.x2", int'(head_x), 6);

        repeat (57) do_step();
        check_head("edge", 63, 0);
        check("edge.length", int'(length), 4);

        do_step();
`ifdef SNAKE_WRAP_EN
        check("wrap.dead", int'(dead), 0);
        check_head("wrap.head", 0, 0);
        check_query("wrap.q63", 63, 0, 1, 0);
        check_query("wrap.q60", 60, 0, 0, 0);
`else
        check("wall.dead", int'(dead), 1);
        check_head("wall.head", 63, 0);
        check_query("wall.q60", 60, 0, 1, 0);
        check_query("wall.q59", 59, 0, 0, 0);
        do_step();
        check("dead.hold", int'(head_x), 63);
        check("dead.stay", int'(dead), 1);
`endif
        pulse_restart();
        check("restart.dead", int'(dead), 0);
        check("restart.length", int'(length), 4);
        check_head("restart.head", 3, 0);
        check_query("restart.q63", 63, 0, 0, 0);
        check_query("restart.q3", 3, 0, 1, 1);

        // Down accepted, then left dropped as the reverse of committed right.
        set_dir(2'd2);
        set_dir(2'd1);
        do_step();
        check_head("down", 3, 1);

        pulse_grow();
        do_step();
        check_head("grow.head", 3, 2);
        check("grow.length", int'(length), 5);
        check_query("grow.oldtail", 1, 0, 1, 0);

        // Grow during CHECK lands on the following step.
        @(negedge clk) step = 1'b1;
        @(negedge clk) begin
            step = 1'b0;
            grow = 1'b1;
        end
        @(negedge clk) grow = 1'b0;
        check("lategrow.len0", int'(length), 5);
        check_head("lategrow.h0", 3, 3);
        do_step();
        check("lategrow.len1", int'(length), 6);
        check_head("lategrow.h1", 3, 4);

        // Reset while in CHECK: nothing of the step survives.
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        check("rstchk.busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rstchk.busy", int'(busy), 0);
        check("rstchk.length", int'(length), 4);
        check_head("rstchk.head", 3, 0);
        @(negedge clk) rst = 1'b0;

        // Length 5 square loop bites its own body.
        pulse_grow();
        do_step();
        check("loop5.length", int'(length), 5);
        set_dir(2'd2);
        do_step();
        set_dir(2'd1);
        do_step();
        check("loop5.alive", int'(dead), 0);
        set_dir(2'd3);
        do_step();
        check("loop5.dead", int'(dead), 1);
        check_head("loop5.head", 3, 1);
        pulse_restart();
        check("loop5.restart", int'(dead), 0);
        check_query("loop5.q41", 4, 1, 0, 0);

        // Length 4 same loop: the tail leaves the target cell in time.
        do_step();
        set_dir(2'd2);
        do_step();
        set_dir(2'd1);
        do_step();
        set_dir(2'd3);
        do_step();
        check("loop4.dead", int'(dead), 0);
        check_head("loop4.head", 3, 0);
        check("loop4.length", int'(length), 4);
        check_query("loop4.q20", 2, 0, 0, 0);
        check_query("loop4.q40", 4, 0, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Parametrised snake body engine: holds up to MAX_LEN grid segments in a circular buffer and advances the snake one cell per `step` pulse. It applies keyboard direction requests with reverse rejection, grows on request, and detects wall and self collision. It sits between the PS/2 decoder and the pixel renderer, replacing the fixed four-segment position array. The renderer reads occupancy through a registered point-query port.

## Interface
- GRID_W, 64, grid columns (x in 0..GRID_W-1)
- GRID_H, 48, grid rows (y in 0..GRID_H-1)
- XW, 7, x coordinate width; YW, 6, y coordinate width
- MAX_LEN, 16, buffer depth / maximum length (≥ INIT_LEN)
- INIT_LEN, 4, length after reset/restart (≥ 2)
- START_X, 3 and START_Y, 0: head cell after reset (START_X ≥ INIT_LEN-1)
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock (clk25 domain)
- rst  in  1  asynchronous, active-high reset
- step  in  1  one-cycle pulse; advance one cell
- restart  in  1  synchronous pulse; reinitialise as reset
- dir_valid  in  1  qualifies dir_req
- dir_req  in  2  0 right (+x), 1 left, 2 down (+y), 3 up
- grow  in  1  pulse; lengthen by one at next committed step
- query_x  in  XW  and  query_y  in  YW: renderer cell
- query_hit  out  1  queried cell holds a live segment (1-cycle latency)
- query_head  out  1  queried cell is the head
- head_x  out  XW  and  head_y  out  YW: current head
- length  out  $clog2(MAX_LEN+1)  live segment count
- busy  out  1  high in CHECK
- dead  out  1  high in DEAD

## Operation
- Segment i (0 = head) is at buffer[(hp+i) mod MAX_LEN]; live for i < length.
- Init (reset/restart): hp=0, seg i = (START_X-i, START_Y), length=INIT_LEN, dir=right, pend_dir=right, grow_pend=0, state RUN.
- States: RUN, CHECK, DEAD.
- RUN + step: compute candidate head from pend_dir into register; commit pend_dir as dir; go to CHECK.
- CHECK (one cycle): wall fail if candidate leaves grid; self fail if candidate equals any live segment i < length, excluding the tail (i = length-1) when grow_pend=0. On fail, go to DEAD with the body unchanged. Otherwise: hp ← hp-1 mod MAX_LEN, write the candidate; if grow_pend and length<MAX_LEN then length+1; clear grow_pend; go to RUN.
- DEAD: hold the body; ignore step/grow/dir; only restart or rst leave.
- step in CHECK or DEAD is ignored (not queued).
- Direction: dir_valid with dir_req equal to the reverse of committed dir is dropped. Otherwise pend_dir ← dir_req. The last accepted request before a step wins.
- grow: sets grow_pend in any state except DEAD. grow_pend is held through CHECK if it arrives during CHECK. At length=MAX_LEN growth is a no-op and the pend flag is cleared.
- restart beats all same-cycle inputs.
- Arithmetic: x,y unsigned. Edge moves (x=GRID_W-1 right, x=0 left, same for y) are wall fails. No negative-coordinate encoding.
- Query: registered. Out-of-grid query yields 0/0. During CHECK the query reflects the pre-step body.

## Timing
- Reset values: query_hit=0, query_head=0, busy=0, dead=0, head=(START_X,START_Y), length=INIT_LEN.
- step at edge N → busy=1 after N → new head/length or dead=1 visible after N+1. Step latency is 2 cycles.
- Query latency: 1 cycle, fully pipelined, one query per cycle.
- rst mid-CHECK: immediate init; no partial commit.

## Configuration
- SNAKE_WRAP_EN defined: edge moves wrap (GRID_W-1→0, 0→GRID_W-1, same for y); only self collision kills.
- Undefined: edge moves are wall fails → DEAD.

## Test plan
- Reset defaults → query (3,0): hit=1, head=1; (0,0): hit=1, head=0; (4,0): hit=0; length=4, dead=0.
- 60 steps right → head_x=63. Next step: dead=1 and body unchanged without the macro; head_x=0, dead=0 with SNAKE_WRAP_EN.
- Moving right, dir_req=left then step → head_x+1 (reverse rejected). dir_req=down then left before step → head moves down.
- grow then step → length=5, old tail cell still hit. grow during CHECK → applied on the following step.
- Length 5: down, left, up → dead=1 after the third step. Length 4 same loop → dead=0 (tail vacates in time).
- step pulses every cycle → only every other is accepted. rst asserted in CHECK → init values next cycle. restart in DEAD → RUN with init body.
